// File: rtl/keyed_mux_n.sv
// Registered N-to-1 selector whose select is loaded serially as a key, committed, then locked until reset.
// Optional build macro KEYED_MUX_PARITY_EN appends an even-parity bit to the key and checks it at commit.
module keyed_mux_n #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] data_in,
  input  logic            in_valid,
  input  logic            key_bit,
  input  logic            key_shift,
  input  logic            key_commit,
  output logic            mux_out,
  output logic            out_valid,
  output logic            sel_locked,
  output logic            key_err
);

  localparam int SEL_W = $clog2(N_IN);
`ifdef KEYED_MUX_PARITY_EN
  localparam int KEY_W = SEL_W + 1;
`else
  localparam int KEY_W = SEL_W;
`endif
  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_IN);

  typedef enum logic [1:0] {
    UNKEYED = 2'd0,
    LOADING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

`ifdef KEYED_MUX_PARITY_EN
  // Even parity: select bits plus trailing parity bit XOR to zero.
  function automatic logic parity_ok(input logic [KEY_W-1:0] key);
    return ~(^key);
  endfunction
`endif

  state_t             state_r, state_nx;
  logic [KEY_W-1:0]   sreg_r, sreg_nx, sreg_sh;
  logic [CNT_W-1:0]   cnt_r, cnt_nx, cnt_sh;
  logic [SEL_W-1:0]   sel_r, sel_nx, key_sel;
  logic               key_valid;
  logic               err_set;

  // Key register as it stands once this cycle's shift has been applied.
  assign sreg_sh = key_shift ? KEY_W'({sreg_r, key_bit}) : sreg_r;

  // Bit counter after this cycle's shift; restarts at 1 from UNKEYED and saturates at the key length.
  always_comb begin
    cnt_sh = cnt_r;
    if (!key_shift) begin
      cnt_sh = cnt_r;
    end else if (state_r == UNKEYED) begin
      cnt_sh = CNT_ONE;
    end else if (cnt_r == CNT_FULL) begin
      cnt_sh = CNT_FULL;
    end else begin
      cnt_sh = cnt_r + CNT_ONE;
    end
  end

`ifdef KEYED_MUX_PARITY_EN
  assign key_sel   = sreg_sh[KEY_W-1:1];
  assign key_valid = ({1'b0, key_sel} < N_LIM) && parity_ok(sreg_sh);
`else
  assign key_sel   = sreg_sh;
  assign key_valid = ({1'b0, key_sel} < N_LIM);
`endif

  // Key-load FSM: shift is applied first, then a commit is judged against the updated key.
  always_comb begin
    state_nx = state_r;
    sreg_nx  = sreg_r;
    cnt_nx   = cnt_r;
    sel_nx   = sel_r;
    err_set  = 1'b0;
    case (state_r)
      UNKEYED, LOADING: begin
        sreg_nx = sreg_sh;
        cnt_nx  = cnt_sh;
        if (key_shift) begin
          state_nx = LOADING;
        end else begin
          state_nx = state_r;
        end
        if (!key_commit) begin
          err_set = 1'b0;
        end else if (!key_shift && (state_r == UNKEYED)) begin
          err_set = 1'b1;
        end else if ((cnt_sh == CNT_FULL) && key_valid) begin
          sel_nx   = key_sel;
          state_nx = LOCKED;
        end else begin
          err_set  = 1'b1;
          state_nx = UNKEYED;
          cnt_nx   = {CNT_W{1'b0}};
        end
      end
      LOCKED: begin
        state_nx = LOCKED;
      end
      default: begin
        state_nx = UNKEYED;
        cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, key and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= UNKEYED;
      sreg_r     <= {KEY_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
      sel_locked <= 1'b0;
      key_err    <= 1'b0;
      mux_out    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_r    <= state_nx;
      sreg_r     <= sreg_nx;
      cnt_r      <= cnt_nx;
      sel_r      <= sel_nx;
      sel_locked <= (state_nx == LOCKED);
      key_err    <= key_err | err_set;
      if (state_r != LOCKED) begin
        mux_out   <= 1'b0;
        out_valid <= 1'b0;
      end else if (in_valid) begin
        mux_out   <= data_in[sel_r];
        out_valid <= 1'b1;
      end else begin
        mux_out   <= mux_out;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keyed_mux_n.sv
// Directed bench for keyed_mux_n: an 8-input and a 6-input instance share one stimulus stream.
module tb_keyed_mux_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       key_bit = 1'b0;
  logic       key_shift = 1'b0;
  logic       key_commit = 1'b0;
  logic       m8, v8, l8, e8;
  logic       m6, v6, l6, e6;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] stream [4];

  always #5 clk = ~clk;

  keyed_mux_n #(.N_IN(8)) u8 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .key_bit(key_bit), .key_shift(key_shift), .key_commit(key_commit),
    .mux_out(m8), .out_valid(v8), .sel_locked(l8), .key_err(e8)
  );

  keyed_mux_n #(.N_IN(6)) u6 (
    .clk(clk), .rst(rst), .data_in(data_in[5:0]), .in_valid(in_valid),
    .key_bit(key_bit), .key_shift(key_shift), .key_commit(key_commit),
    .mux_out(m6), .out_valid(v6), .sel_locked(l6), .key_err(e6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic em, input logic ev, input logic el, input logic ee);
    chk({tag, ".mux_out"}, m8, em);
    chk({tag, ".out_valid"}, v8, ev);
    chk({tag, ".sel_locked"}, l8, el);
    chk({tag, ".key_err"}, e8, ee);
  endtask

  task automatic shift_bit(input logic b);
    key_bit   = b;
    key_shift = 1'b1;
    tick();
    key_shift = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  // Shifts a 3-bit select MSB first (plus its parity bit when enabled); optionally commits on the last shift.
  task automatic load_key(input logic [2:0] k, input logic commit_last);
    logic [3:0] bits;
    int nb;
`ifdef KEYED_MUX_PARITY_EN
    bits = {k, ^k};
    nb = 4;
`else
    bits = {1'b0, k};
    nb = 3;
`endif
    for (int i = nb - 1; i >= 0; i--) begin
      key_bit    = bits[i];
      key_shift  = 1'b1;
      key_commit = commit_last && (i == 0);
      tick();
    end
    key_shift  = 1'b0;
    key_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and idle: data ignored while unkeyed.
    rst = 1'b1;
    tick();
    tick();
    chk8("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      tick();
      chk8("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Normal lock on select 5; data offered in the commit cycle is not sampled.
    load_key(3'b101, 1'b0);
    in_valid = 1'b1;
    data_in = 8'hFF;
    commit();
    chk8("commit_cycle", 1'b0, 1'b0, 1'b1, 1'b0);
    data_in = 8'b0010_0000;
    tick();
    chk8("sel5_hi", 1'b1, 1'b1, 1'b1, 1'b0);
    data_in = 8'hDF;
    tick();
    chk8("sel5_lo", 1'b0, 1'b1, 1'b1, 1'b0);
    data_in = 8'h20;
    tick();
    in_valid = 1'b0;
    data_in = 8'h00;
    tick();
    chk8("hold_no_valid", 1'b1, 1'b0, 1'b1, 1'b0);

    // Short key errors, later full load still locks with key_err sticky.
    do_reset();
    shift_bit(1'b1);
    shift_bit(1'b1);
    commit();
    chk8("short_key", 1'b0, 1'b0, 1'b0, 1'b1);
    load_key(3'b011, 1'b0);
    commit();
    chk8("relock_sel3", 1'b0, 1'b0, 1'b1, 1'b1);
    data_in = 8'b0000_1000;
    in_valid = 1'b1;
    tick();
    chk8("sel3_hi", 1'b1, 1'b1, 1'b1, 1'b1);
    data_in = 8'hF7;
    tick();
    chk8("sel3_lo", 1'b0, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;

    // Out-of-range key on the 6-input instance; the 8-input one accepts it.
    do_reset();
    load_key(3'b110, 1'b0);
    commit();
    chk("oor6.key_err", e6, 1'b1);
    chk("oor6.sel_locked", l6, 1'b0);
    chk("oor8.sel_locked", l8, 1'b1);
    load_key(3'b101, 1'b0);
    commit();
    chk("n6_sel5.sel_locked", l6, 1'b1);
    data_in = 8'b0010_0000;
    in_valid = 1'b1;
    tick();
    chk("n6_sel5.mux_out", m6, 1'b1);
    chk("n6_sel5.out_valid", v6, 1'b1);
    data_in = 8'hDF;
    tick();
    chk("n6_sel5_lo.mux_out", m6, 1'b0);
    in_valid = 1'b0;

    // Commit while unkeyed, overshift with same-cycle shift+commit, immunity while locked.
    do_reset();
    commit();
    chk8("unkeyed_commit", 1'b0, 1'b0, 1'b0, 1'b1);
    shift_bit(1'b1);
    load_key(3'b011, 1'b1);
    chk8("overshift_lock", 1'b0, 1'b0, 1'b1, 1'b1);
    load_key(3'b101, 1'b1);
    commit();
    chk8("locked_immune", 1'b0, 1'b0, 1'b1, 1'b1);
    stream[0] = 8'h5A;
    stream[1] = 8'hA5;
    stream[2] = 8'hF7;
    stream[3] = 8'h08;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = stream[i];
      tick();
      chk("stream.mux_out", m8, stream[i][3]);
      chk("stream.out_valid", v8, 1'b1);
    end
    in_valid = 1'b0;
    data_in = 8'h00;
    tick();
    chk8("stream_hold", 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset while locked clears everything, and data stays ignored afterwards.
    in_valid = 1'b1;
    data_in = 8'hFF;
    rst = 1'b1;
    tick();
    chk8("rst_locked", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk8("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;

`ifdef KEYED_MUX_PARITY_EN
    // Parity: select 101 with parity 1 is rejected, parity 0 locks.
    do_reset();
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b1);
    commit();
    chk8("parity_bad", 1'b0, 1'b0, 1'b0, 1'b1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    commit();
    chk8("parity_good", 1'b0, 1'b0, 1'b1, 1'b1);
    data_in = 8'b0010_0000;
    in_valid = 1'b1;
    tick();
    chk8("parity_sel5", 1'b1, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
